// File: rtl/lau_pkg.sv
// Shared types for the slice-based counters and the population-count accumulator.
package lau_pkg;

  typedef enum logic {SLOW, FAST} speed_e;

  typedef enum logic {ACC, DONE} popacc_state_e;

  function automatic int cnt_width(input int m);
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/cnt_m_k.sv
// Combinational (m,k) ones counter: m input bits reduced to a k = cnt_width(m) bit count.
// SLOW chains one adder per input bit; FAST reduces the bits through a balanced adder tree.
module cnt_m_k
  import lau_pkg::*;
#(
  parameter int     m     = 16,
  parameter speed_e speed = FAST
) (
  input  logic [m-1:0]            data_i,
  output logic [cnt_width(m)-1:0] cnt_o
);

  localparam int KW = cnt_width(m);

  if (speed == SLOW) begin : g_slow
    always_comb begin
      cnt_o = '0;
      for (int unsigned i = 0; i < m; i++) begin
        cnt_o = cnt_o + KW'(data_i[i]);
      end
    end
  end else begin : g_fast
    localparam int unsigned NP = 1 << $clog2(m);

    logic [NP-1:0] padded;
    logic [KW-1:0] part [NP];

    assign padded = NP'(data_i);

    // Pairwise in-place reduction: each level halves the number of live partial counts.
    always_comb begin
      for (int unsigned i = 0; i < NP; i++) begin
        part[i] = KW'(padded[i]);
      end
      for (int unsigned s = NP / 2; s > 0; s = s / 2) begin
        for (int unsigned i = 0; i < s; i++) begin
          part[i] = part[2*i] + part[2*i+1];
        end
      end
      cnt_o = part[0];
    end
  end

endmodule

// File: rtl/pop_cnt_acc.sv
// Per-packet population-count accumulator with valid/ready on both sides.
// Define POP_CNT_ACC_SAT_EN for a saturating accumulator with sticky overflow flag.
module pop_cnt_acc
  import lau_pkg::*;
#(
  parameter int     width    = 16,
  parameter int     accWidth = 32,
  parameter speed_e speed    = FAST
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                InValid,
  output logic                InReady,
  input  logic [width-1:0]    InData,
  input  logic                InLast,
  output logic                OutValid,
  input  logic                OutReady,
  output logic [accWidth-1:0] OutCount,
  output logic                OutOvf
);

  localparam int KW = cnt_width(width);

  popacc_state_e       state_q, state_d;
  logic                vld_q, vld_d;
  logic                last_q, last_d;
  logic [KW-1:0]       cnt_q, cnt_d;
  logic [accWidth-1:0] acc_q, acc_d;
  logic                ovf_q, ovf_d;
  logic                out_valid_q, out_valid_d;
  logic [accWidth-1:0] out_count_q, out_count_d;
  logic                out_ovf_q, out_ovf_d;

  logic [KW-1:0]       beat_cnt;
  logic [accWidth-1:0] sum;
  logic                carry;
  logic                accept;
  logic                absorb;

  cnt_m_k #(
    .m    (width),
    .speed(speed)
  ) u_cnt (
    .data_i(InData),
    .cnt_o (beat_cnt)
  );

  assign InReady = !vld_q || (state_q == ACC);
  assign accept  = InValid && InReady;

`ifdef POP_CNT_ACC_SAT_EN
  logic [accWidth:0] sum_ext;
  assign sum_ext = {1'b0, acc_q} + (accWidth + 1)'(cnt_q);
  assign carry   = sum_ext[accWidth];
  assign sum     = carry ? '1 : sum_ext[accWidth-1:0];
`else
  assign sum   = acc_q + accWidth'(cnt_q);
  assign carry = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    vld_d       = vld_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    absorb      = 1'b0;

    case (state_q)
      ACC: begin
        if (vld_q) begin
          absorb = 1'b1;
          if (last_q) begin
            out_count_d = sum;
            out_ovf_d   = ovf_q | carry;
            out_valid_d = 1'b1;
            acc_d       = '0;
            ovf_d       = 1'b0;
            state_d     = DONE;
          end else begin
            acc_d = sum;
            ovf_d = ovf_q | carry;
          end
        end
      end
      DONE: begin
        if (OutReady) begin
          out_valid_d = 1'b0;
          state_d     = ACC;
        end
      end
      default: state_d = ACC;
    endcase

    // A beat accepted in the same cycle as the absorb refills the stage.
    if (accept) begin
      vld_d  = 1'b1;
      cnt_d  = beat_cnt;
      last_d = InLast;
    end else if (absorb) begin
      vld_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ACC;
      vld_q       <= 1'b0;
      last_q      <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      vld_q       <= vld_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign OutValid = out_valid_q;
  assign OutCount = out_count_q;
  assign OutOvf   = out_ovf_q;

endmodule
